// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key-schedule blocks: round count,
// FSM encoding, S-box table, rcon lookup and RotWord byte mapping.
package aes_pkg;

    localparam int NR = 10;
    localparam int RW = $clog2(NR + 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(NR);
    localparam logic [RW-1:0] ROUND_ONE  = RW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_EMIT
    } state_t;

    // Forward AES S-box; element 0 sits in the leftmost literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constant for rounds 1..NR; any other index yields zero.
    function automatic logic [7:0] rcon(input logic [RW-1:0] r);
        case (int'(r))
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte 0 lives in [7:0]; RotWord moves every byte down one lane.
    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[7:0], x[31:24], x[23:16], x[15:8]};
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One inverse AES-128 key-schedule step: round r key -> round r-1 key.
module aes_inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0]  i_key,
    input  logic [RW-1:0] i_round,
    output logic [127:0]  o_key
);

    logic [31:0] w_p0, w_p1, w_p2, w_p3;
    logic [31:0] w_rot;
    logic [31:0] w_sub;

    assign w_p3  = i_key[127:96] ^ i_key[95:64];
    assign w_p2  = i_key[95:64]  ^ i_key[63:32];
    assign w_p1  = i_key[63:32]  ^ i_key[31:0];
    assign w_rot = rot_word(w_p3);

    for (genvar g = 0; g < 4; g++) begin : g_lut
        aes_sub_lut u_lut (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_p0  = i_key[31:0] ^ w_sub ^ {24'h0, rcon(i_round)};
    assign o_key = {w_p3, w_p2, w_p1, w_p0};

endmodule

// File: rtl/aes_sub_lut.sv
// Single-byte S-box lookup.
module aes_sub_lut
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/key_expansion.sv
// One forward AES-128 key-schedule step: round r-1 key -> round r key.
module key_expansion
    import aes_pkg::*;
(
    input  logic [127:0]  i_key,
    input  logic [RW-1:0] r_i,
    output logic [127:0]  o_key
);

    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_rot = rot_word(i_key[127:96]);

    for (genvar g = 0; g < 4; g++) begin : g_lut
        aes_sub_lut u_lut (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_t  = w_sub ^ {24'h0, rcon(r_i)};
    assign w_n0 = i_key[31:0]   ^ w_t;
    assign w_n1 = i_key[63:32]  ^ w_n0;
    assign w_n2 = i_key[95:64]  ^ w_n1;
    assign w_n3 = i_key[127:96] ^ w_n2;

    assign o_key = {w_n3, w_n2, w_n1, w_n0};

endmodule

// File: rtl/aes_key_unroll.sv
// Inverse AES-128 key scheduler: optional forward pre-pass to round 10,
// then streams round keys 10..0 over a valid/ready handshake.
module aes_key_unroll
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic         key_is_final,
    input  logic [127:0] key_in,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [127:0]    r_key;
    logic [RW-1:0]   r_round;
    logic            r_done;
    logic [127:0]    w_fwd_key;
    logic [127:0]    w_inv_key;
    logic            w_accept;

    key_expansion u_fwd (
        .i_key (r_key),
        .r_i   (r_round),
        .o_key (w_fwd_key)
    );

    aes_inv_key_step u_inv (
        .i_key   (r_key),
        .i_round (r_round),
        .o_key   (w_inv_key)
    );

    assign w_accept = key_valid & key_ready;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path leaves w_state_nxt unassigned
        // (which would infer a latch).
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = key_is_final ? ST_EMIT : ST_FWD;
            ST_FWD:  if (r_round == ROUND_LAST) w_state_nxt = ST_EMIT;
            ST_EMIT: if (w_accept && r_round == '0) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Key register, round counter and done pulse; key source muxed by state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the 128-bit key register is a plain flop bank, not a
            // memory, so it is cleared here along with the control state.
            r_key   <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_key   <= key_in;
                        r_round <= key_is_final ? ROUND_LAST : ROUND_ONE;
                    end
                end
                ST_FWD: begin
                    r_key   <= w_fwd_key;
                    r_round <= (r_round == ROUND_LAST) ? ROUND_LAST : r_round + 1'b1;
                end
                ST_EMIT: begin
                    if (w_accept) begin
                        if (r_round == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_key   <= w_inv_key;
                            r_round <= r_round - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_valid = (r_state == ST_EMIT);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign key_out   = r_key;
    assign round_out = r_round;

endmodule

// File: tb/tb_aes_key_unroll.sv
// Directed bench for aes_key_unroll using the FIPS-197 A.1 key schedule.
module tb_aes_key_unroll;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic         key_is_final;
    logic [127:0] key_in;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Round keys in FIPS byte order (byte 0 leftmost).
    logic [127:0] fips [0:10];

    aes_key_unroll dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .key_is_final (key_is_final),
        .key_in       (key_in),
        .key_out      (key_out),
        .round_out    (round_out),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // The DUT puts byte 0 at [7:0]: a full byte reversal of FIPS order.
    function automatic logic [127:0] exp_key(input int r);
        logic [127:0] f;
        logic [127:0] k;
        f = fips[r];
        k = '0;
        for (int b = 0; b < 16; b++) k[8*b +: 8] = f[127-8*b -: 8];
        return k;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start; caller is at a negedge.
    task automatic start_job(input bit fin);
        key_is_final = fin;
        key_in       = fin ? exp_key(10) : exp_key(0);
        start        = 1'b1;
        @(negedge CLK);
        start        = 1'b0;
    endtask

    // Start a job and consume all 11 keys, checking latency, order and hold.
    task automatic run_job(input bit fin, input int duty, input bit inject, input bit fall_chk);
        int  lows;
        int  r;
        int  budget;
        bit  acc;
        bit  fin_seen;
        start_job(fin);
        key_ready = 1'b1;
        lows = 0;
        while (!key_valid && lows < 40) begin
            check($sformatf("busy_fwd_%0d", lows), busy, 1);
            start = inject && (lows == 3);
            if (start) begin
                key_is_final = 1'b1;
                key_in       = 128'hdeadbeef_00112233_44556677_8899aabb;
            end
            @(negedge CLK);
            lows++;
        end
        start = 1'b0;
        check("latency_low_cycles", lows, fin ? 0 : 10);
        r = 10;
        budget = 0;
        fin_seen = 1'b0;
        while (!fin_seen && budget < 400) begin
            check($sformatf("valid_r%0d", r), key_valid, 1);
            check($sformatf("round_r%0d", r), round_out, r);
            check($sformatf("key_r%0d", r), key_out, exp_key(r));
            key_ready = (duty >= 100) ? 1'b1 : ($urandom_range(99, 0) < duty);
            start = inject && (r == 6);
            if (start) begin
                key_is_final = 1'b0;
                key_in       = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
            end
            acc = key_ready;
            @(negedge CLK);
            start = 1'b0;
            budget++;
            if (acc) begin
                if (r == 0) fin_seen = 1'b1;
                else        r--;
            end
        end
        check("stream_completed", fin_seen, 1);
        check("done_pulse", done, 1);
        check("busy_after_done", busy, 0);
        check("valid_after_done", key_valid, 0);
        if (fall_chk) begin
            @(negedge CLK);
            check("done_falls", done, 0);
        end
    endtask

    initial begin
        int n;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset state
        RST = 1'b1; start = 1'b0; key_is_final = 1'b0; key_in = '0; key_ready = 1'b0;
        #1;
        check("rst_key_out", key_out, 0);
        check("rst_round_out", round_out, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("layout_round10", exp_key(10), 128'ha60c63b6c80c3fe18925eec9a8f914d0);
        @(negedge CLK);

        // Final-key load, then cipher-key load, ready held high
        run_job(1'b1, 100, 1'b0, 1'b1);
        run_job(1'b0, 100, 1'b0, 1'b1);

        // Backpressure at about 30% ready duty
        run_job(1'b1, 30, 1'b0, 1'b1);
        run_job(1'b0, 30, 1'b0, 1'b1);

        // Start pulses during FWD and EMIT are ignored
        run_job(1'b0, 100, 1'b1, 1'b1);

        // Async reset while round 5 is presented
        start_job(1'b1);
        key_ready = 1'b1;
        n = 0;
        while (round_out != 4'd5 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("reach_round5", round_out, 5);
        key_ready = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("arst_valid", key_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_round", round_out, 0);
        check("arst_key", key_out, 0);
        @(negedge CLK);
        @(negedge CLK);
        check("arst_no_done", done, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_done", done, 0);
        run_job(1'b0, 100, 1'b0, 1'b1);

        // Back-to-back: next start issued in the done cycle
        run_job(1'b1, 100, 1'b0, 1'b0);
        run_job(1'b0, 100, 1'b0, 1'b0);
        run_job(1'b1, 30, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
